// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_pkg: shared types and address layout for the data-memory cache
// controller (data_mem_ctrl) and its line store (data_mem_line_store).
//   - state_t      : controller FSM states
//   - TAG_W/IDX_W/WORD_W and field offsets for the default geometry
//   - split_addr   : byte address -> {tag, index, word, lsb}
//   - join_addr    : {tag, index, word} -> word-aligned byte address
package data_mem_pkg;

  localparam int unsigned LINES_DEF = 32;
  localparam int unsigned WORDS_DEF = 4;
  localparam int unsigned WORD_W    = 2;
  localparam int unsigned IDX_W     = $clog2(LINES_DEF);
  localparam int unsigned WORD_LSB  = 1;
  localparam int unsigned IDX_LSB   = WORD_LSB + WORD_W;
  localparam int unsigned TAG_LSB   = IDX_LSB + IDX_W;
  localparam int unsigned TAG_W     = 16 - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RESP
  } state_t;

  // Field order matches the bit layout of a 16-bit byte address.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic              lsb;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [15:0] a);
    return addr_fields_t'(a);
  endfunction

  function automatic logic [15:0] join_addr(input logic [TAG_W-1:0]  tag,
                                            input logic [IDX_W-1:0]  idx,
                                            input logic [WORD_W-1:0] word);
    return {tag, idx, word, 1'b0};
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: MEM-stage request/response signals plus the word-serial
// backing-memory handshake.
//   slave  : the cache controller (receives Addr/DataIn/Rd/Wr and mem_ack/
//            mem_rdata/mem_err; drives DataOut/Done/Stall/CacheHit/err and
//            mem_req/mem_we/mem_addr/mem_wdata)
//   master : the pipeline plus backing memory side (opposite directions)
interface data_mem_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_err;

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_ack, mem_rdata, mem_err,
    output DataOut, Done, Stall, CacheHit, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output Addr, DataIn, Rd, Wr, mem_ack, mem_rdata, mem_err,
    input  DataOut, Done, Stall, CacheHit, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_line_store.sv
// data_mem_line_store: tag/valid/dirty/data arrays of the direct-mapped cache.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset (clears valid/dirty)
//   i_idx             : line index; o_tag/o_valid/o_dirty/o_line read it
//                       combinationally
//   i_we_word         : write i_wdata into word i_word_sel of line i_idx
//   i_inv             : clear valid and dirty of line i_idx
//   i_install, i_tag  : install tag, set valid, clear dirty (wins over i_inv)
//   i_set_dirty       : set dirty of line i_idx
module data_mem_line_store
  import data_mem_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [TAG_W-1:0]       o_tag,
  output logic                   o_valid,
  output logic                   o_dirty,
  output logic [WORDS-1:0][15:0] o_line,
  input  logic                   i_we_word,
  input  logic [WORD_W-1:0]      i_word_sel,
  input  logic [15:0]            i_wdata,
  input  logic                   i_inv,
  input  logic                   i_install,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic                   i_set_dirty
);

  logic [LINES-1:0]       r_valid;
  logic [LINES-1:0]       r_dirty;
  logic [TAG_W-1:0]       r_tag  [LINES];
  logic [WORDS-1:0][15:0] r_data [LINES];

  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_inv) begin
        r_valid[i_idx] <= 1'b0;
        r_dirty[i_idx] <= 1'b0;
      end
      if (i_install) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end
      if (i_set_dirty) begin
        r_dirty[i_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we_word) begin
      r_data[i_idx][i_word_sel] <= i_wdata;
    end
    if (i_install) begin
      r_tag[i_idx] <= i_tag;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: direct-mapped, write-back, write-allocate data cache that
// answers MEM-stage requests and talks word-serially to backing memory.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : data_mem_ctrl_if.slave (request/response + backing memory)
//   hit_count, miss_count : 16-bit saturating counters of completed,
//                error-free hits/misses; present only with
//                DATA_MEM_CTRL_STATS_EN defined
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_ctrl_if.slave   bus
`ifdef DATA_MEM_CTRL_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  state_t                 r_state, w_next;
  logic [WORD_W-1:0]      r_cnt, w_cnt_nxt;
  logic                   r_err, w_err_nxt;

  addr_fields_t           w_a;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_valid, w_dirty, w_hit, w_req, w_illegal;
  logic [WORDS-1:0][15:0] w_line;

  logic                   w_we_word, w_inv, w_install, w_set_dirty;
  logic [WORD_W-1:0]      w_word_sel;
  logic [15:0]            w_wdata;

  logic                   w_done, w_stall, w_hit_o, w_err_o, w_mreq, w_mwe;
  logic [15:0]            w_dout, w_maddr, w_mwdata;

  assign w_a       = split_addr(bus.Addr);
  assign w_hit     = w_valid && (w_tag == w_a.tag);
  assign w_req     = bus.Rd | bus.Wr;
  assign w_illegal = (bus.Rd & bus.Wr) | (w_req & w_a.lsb);

  data_mem_line_store #(.LINES(LINES), .WORDS(WORDS)) u_store (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_idx       (w_a.idx),
    .o_tag       (w_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_line      (w_line),
    .i_we_word   (w_we_word),
    .i_word_sel  (w_word_sel),
    .i_wdata     (w_wdata),
    .i_inv       (w_inv),
    .i_install   (w_install),
    .i_tag       (w_a.tag),
    .i_set_dirty (w_set_dirty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_done      = 1'b0;
    w_stall     = 1'b0;
    w_hit_o     = 1'b0;
    w_err_o     = 1'b0;
    w_dout      = '0;
    w_mreq      = 1'b0;
    w_mwe       = 1'b0;
    w_maddr     = '0;
    w_mwdata    = '0;
    w_we_word   = 1'b0;
    w_word_sel  = w_a.word;
    w_wdata     = bus.DataIn;
    w_inv       = 1'b0;
    w_install   = 1'b0;
    w_set_dirty = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_err_nxt = 1'b0;
        if (w_illegal) begin
          w_done  = 1'b1;
          w_err_o = 1'b1;
        end else if (w_req) begin
          if (w_hit) begin
            w_done  = 1'b1;
            w_hit_o = 1'b1;
            if (bus.Rd) w_dout = w_line[w_a.word];
            if (bus.Wr) begin
              w_we_word   = 1'b1;
              w_set_dirty = 1'b1;
            end
          end else begin
            w_stall = 1'b1;
            w_next  = (w_valid && w_dirty) ? WB : FILL;
          end
        end
      end

      WB: begin
        w_stall  = 1'b1;
        w_mreq   = 1'b1;
        w_mwe    = 1'b1;
        w_maddr  = join_addr(w_tag, w_a.idx, r_cnt);
        w_mwdata = w_line[r_cnt];
        if (bus.mem_ack) begin
          if (bus.mem_err) begin
            w_inv     = 1'b1;
            w_err_nxt = 1'b1;
            w_cnt_nxt = '0;
            w_next    = RESP;
          end else if (r_cnt == 2'd3) begin
            w_cnt_nxt = '0;
            w_next    = FILL;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end

      FILL: begin
        w_stall = 1'b1;
        w_mreq  = 1'b1;
        w_maddr = join_addr(w_a.tag, w_a.idx, r_cnt);
        if (bus.mem_ack) begin
          if (bus.mem_err) begin
            w_inv     = 1'b1;
            w_err_nxt = 1'b1;
            w_cnt_nxt = '0;
            w_next    = RESP;
          end else begin
            // Every fill word keeps the line invalid until the last word
            // installs the new tag, so an abort leaves no stale-valid line.
            w_we_word  = 1'b1;
            w_word_sel = r_cnt;
            w_wdata    = bus.mem_rdata;
            w_inv      = 1'b1;
            if (r_cnt == 2'd3) begin
              w_install = 1'b1;
              w_cnt_nxt = '0;
              w_next    = RESP;
            end else begin
              w_cnt_nxt = r_cnt + 2'd1;
            end
          end
        end
      end

      RESP: begin
        w_done    = 1'b1;
        w_err_o   = r_err;
        w_err_nxt = 1'b0;
        w_next    = IDLE;
        if (!r_err) begin
          if (bus.Rd) w_dout = w_line[w_a.word];
          if (bus.Wr) begin
            w_we_word   = 1'b1;
            w_set_dirty = 1'b1;
          end
        end
      end

      default: w_next = IDLE;
    endcase

    if (rst) begin
      w_done      = 1'b0;
      w_stall     = 1'b0;
      w_hit_o     = 1'b0;
      w_err_o     = 1'b0;
      w_dout      = '0;
      w_mreq      = 1'b0;
      w_mwe       = 1'b0;
      w_maddr     = '0;
      w_mwdata    = '0;
      w_we_word   = 1'b0;
      w_inv       = 1'b0;
      w_install   = 1'b0;
      w_set_dirty = 1'b0;
    end
  end

  assign bus.DataOut   = w_dout;
  assign bus.Done      = w_done;
  assign bus.Stall     = w_stall;
  assign bus.CacheHit  = w_hit_o;
  assign bus.err       = w_err_o;
  assign bus.mem_req   = w_mreq;
  assign bus.mem_we    = w_mwe;
  assign bus.mem_addr  = w_maddr;
  assign bus.mem_wdata = w_mwdata;

`ifdef DATA_MEM_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_done && !w_err_o) begin
      if (w_hit_o) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder at the far end of the MEM-stage data-memory interface. It produces DataOut, Done, Stall, CacheHit and err, which the pipeline latches into MEM/WB.
- Implements a direct-mapped, write-back, write-allocate data cache with a word-serial handshake to backing memory.
- Sits between the MEM stage (requester) and the backing data memory.

Parameters:
- LINES, 32, number of cache lines; power of two; index width IDX_W = log2(LINES).
- WORDS, 4, 16-bit words per line; fixed at 4 in this revision.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; sampled on rising clk
- Addr  in  16  byte address. Tag is Addr[15:8] with default LINES; index is Addr[7:3]; word is Addr[2:1]; Addr[0] must be 0.
- DataIn  in  16  write data
- Rd  in  1  read request
- Wr  in  1  write request
- DataOut  out  16  read data, valid when Done=1 for a read
- Done  out  1  request complete this cycle
- Stall  out  1  requester must hold Addr/DataIn/Rd/Wr stable
- CacheHit  out  1  completed request hit; qualified by Done
- err  out  1  request rejected; qualified by Done
- mem_req  out  1  backing-memory word request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  16  word-aligned backing address
- mem_wdata  out  16  write data to backing memory
- mem_ack  in  1  backing-memory word complete; mem_rdata valid in this cycle for reads
- mem_rdata  in  16  backing read data
- mem_err  in  1  backing error, qualified by mem_ack

Behaviour:
- Reset (synchronous):
  - All valid and dirty bits cleared in one cycle; FSM returns to IDLE.
  - Outputs reset to: Done, Stall, CacheHit, err, mem_req, mem_we = 0; DataOut, mem_addr, mem_wdata = 0.
  - Reset mid-miss abandons the transfer immediately; dirty data is lost, which is intended.
- States: IDLE, WB (word counter 0..3), FILL (word counter 0..3), RESP.
- IDLE, no request (Rd=Wr=0): all outputs 0.
- IDLE, illegal request (Rd&Wr, or Addr[0]=1 with Rd|Wr):
  - Same cycle: Done=1, err=1, CacheHit=0, Stall=0.
  - No array or memory access.
- IDLE, hit (valid and tag match):
  - Zero-latency: Done=1, CacheHit=1, Stall=0 in the same cycle.
  - Read: DataOut = word.
  - Write: word is written and dirty is set at the clock edge.
- IDLE, miss:
  - Stall=1 in the same cycle.
  - Next state is WB if the victim is valid and dirty, else FILL.
- WB:
  - Word n of the victim is written to {victim tag, index, n, 1'b0}.
  - mem_req=1 and mem_we=1 are held until mem_ack; the counter then increments.
  - After word 3 is acked, go to FILL.
- FILL:
  - Word n is read from {Addr tag, index, n, 1'b0}.
  - On mem_ack, the word is written to the line.
  - After word 3: set tag and valid, clear dirty, go to RESP.
- RESP:
  - Done=1, CacheHit=0, Stall=0.
  - Read: DataOut = requested word.
  - Write: word is merged and dirty is set at this edge.
  - Next state is IDLE. Rd/Wr are ignored in RESP; the next request is evaluated in IDLE the following cycle.
- Stall=1 in every WB/FILL cycle and in the miss-detect cycle.
- mem_err with mem_ack:
  - Abort the transfer and leave the line invalid.
  - Go to RESP with err=1 and CacheHit=0.
- mem_ack while mem_req=0 is ignored.
- Address arithmetic: the word counter wraps 3→0 only at state exit. mem_addr is always even.

Optional Feature:
- Macro: DATA_MEM_CTRL_STATS_EN.
- When defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments by 1 on each Done with err=0: hit_count if CacheHit=1, miss_count otherwise.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package data_mem_pkg holds:
  - the state enum (IDLE, WB, FILL, RESP);
  - TAG_W, IDX_W, WORD_W=2 and field-offset constants;
  - an address-split helper.
- Sub-module data_mem_line_store holds the tag/valid/dirty/data arrays:
  - combinational read;
  - one write port (word write, tag install, valid/dirty set and clear);
  - synchronous valid clear on rst.
- The FSM and handshake stay in data_mem_ctrl.

Test Plan:
- Cold read, then re-read:
  - Reset, then Rd Addr=16'h0010 with backing word 16'hBEEF (ack latency 2 per word) → 4 FILL reads at addresses 0x0010, 0x0012, 0x0014, 0x0016.
  - RESP has DataOut=16'hBEEF, CacheHit=0.
  - Re-read the same address → Done and CacheHit in the same cycle, Stall=0.
- Write hit then dirty eviction:
  - Wr 16'h1234 to 0x0010 → hit.
  - Rd 0x1010 (same index, tag 0x10) → 4 WB writes to 0x0010–0x0016 including 16'h1234, then 4 FILL reads, then RESP.
- Illegal requests:
  - Rd=Wr=1 → Done=1, err=1, mem_req stays 0.
  - Rd with Addr=16'h0003 → same response.
- Backing error: mem_err with mem_ack on FILL word 1 → RESP with err=1; the next Rd of the same address misses again.
- Reset mid-WB: assert rst during the WB word-2 wait → next cycle mem_req=0, Stall=0; the line previously dirty now misses.
- DATA_MEM_CTRL_STATS_EN: 3 hits and 2 misses → hit_count=3, miss_count=2; err requests are not counted.
